// File: rtl/isa_pkg.sv
// Shared definitions for the 9-bit ISA fetch path: widths, the HALT encoding,
// the fetch FSM state type and the program-counter type.
package isa_pkg;

   localparam int AW = 12;
   localparam int IW = 9;
   localparam int CW = 16;
   localparam logic [IW-1:0] HALT_OP = 9'h1FF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } fetch_state_t;

   typedef logic [AW-1:0] pc_t;

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter: absolute load has priority over increment, otherwise holds.
// Increment wraps modulo 2**AW silently.
module pc_reg #(
   parameter int AW = isa_pkg::AW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [AW-1:0] load_val,
   input  logic          inc,
   output logic [AW-1:0] pc
);

   logic [AW-1:0] pc_q;
   logic [AW-1:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      if (load) begin
         pc_d = load_val;
      end else if (inc) begin
         pc_d = pc_q + AW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch unit: drives the ROM address from the PC, registers the returned word
// into a one-entry fetch register for decode, and sequences one program per Start.
module instr_fetch #(
   parameter int             AW      = isa_pkg::AW,
   parameter int             IW      = isa_pkg::IW,
   parameter logic [IW-1:0]  HALT_OP = isa_pkg::HALT_OP,
   parameter int             CW      = isa_pkg::CW
) (
   input  logic          Clk,
   input  logic          Reset_n,
   input  logic          Start,
   input  logic [AW-1:0] StartAddr,
   output logic [AW-1:0] InstAddress,
   input  logic [IW-1:0] InstrIn,
   output logic          InstrValid,
   input  logic          InstrReady,
   output logic [IW-1:0] Instr,
   output logic [AW-1:0] InstrPC,
   input  logic          BranchTaken,
   input  logic [AW-1:0] BranchTarget,
   output logic          Done,
   output logic [CW-1:0] CycleCount
);

   import isa_pkg::*;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (&v) ? v : v + CW'(1);
   endfunction

   fetch_state_t  state_q, state_d;
   logic          vld_q, vld_d;
   logic [IW-1:0] instr_q, instr_d;
   logic [AW-1:0] ipc_q, ipc_d;
   logic          done_q, done_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          take;
   logic          pc_load;
   logic          pc_inc;
   logic [AW-1:0] pc_load_val;
   logic [AW-1:0] pc;

   pc_reg #(.AW(AW)) u_pc (
      .clk      (Clk),
      .rst_n    (Reset_n),
      .load     (pc_load),
      .load_val (pc_load_val),
      .inc      (pc_inc),
      .pc       (pc)
   );

   always_comb begin
      state_d     = state_q;
      vld_d       = vld_q;
      instr_d     = instr_q;
      ipc_d       = ipc_q;
      done_d      = done_q;
      cnt_d       = cnt_q;
      pc_load     = 1'b0;
      pc_inc      = 1'b0;
      pc_load_val = StartAddr;
      take        = !vld_q || InstrReady;

      case (state_q)
         IDLE, DONE: begin
            // Start outranks a stray BranchTaken while no program is running
            if (Start) begin
               state_d     = RUN;
               pc_load     = 1'b1;
               pc_load_val = StartAddr;
               cnt_d       = '0;
               done_d      = 1'b0;
               vld_d       = 1'b0;
            end
         end
         RUN: begin
            cnt_d = sat_inc(cnt_q);
            if (BranchTaken) begin
               pc_load     = 1'b1;
               pc_load_val = BranchTarget;
               vld_d       = 1'b0;
            end else if (take) begin
               instr_d = InstrIn;
               ipc_d   = pc;
               vld_d   = 1'b1;
               // HALT parks the PC on itself so no word past the program is fetched
               if (InstrIn == HALT_OP) begin
                  state_d = DRAIN;
               end else begin
                  pc_inc = 1'b1;
               end
            end
         end
         DRAIN: begin
            cnt_d = sat_inc(cnt_q);
            if (BranchTaken) begin
               pc_load     = 1'b1;
               pc_load_val = BranchTarget;
               vld_d       = 1'b0;
               state_d     = RUN;
            end else if (vld_q && InstrReady) begin
               vld_d   = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         vld_q   <= 1'b0;
         instr_q <= '0;
         ipc_q   <= '0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         vld_q   <= vld_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
      end
   end

   assign InstAddress = pc;
   assign InstrValid  = vld_q;
   assign Instr       = instr_q;
   assign InstrPC     = ipc_q;
   assign Done        = done_q;
   assign CycleCount  = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a program-level model predicts the ordered stream of
// (PC, word) pairs decode should accept, and a negedge monitor checks it.
module tb_instr_fetch;

   localparam int AW = 12;
   localparam int IW = 9;
   localparam int CW = 16;
   localparam logic [IW-1:0] HALT = 9'h1FF;

   logic          Clk;
   logic          Reset_n;
   logic          Start;
   logic [AW-1:0] StartAddr;
   logic [AW-1:0] InstAddress;
   logic [IW-1:0] InstrIn;
   logic          InstrValid;
   logic          InstrReady;
   logic [IW-1:0] Instr;
   logic [AW-1:0] InstrPC;
   logic          BranchTaken;
   logic [AW-1:0] BranchTarget;
   logic          Done;
   logic [CW-1:0] CycleCount;

   logic [IW-1:0] rom [0:4095];

   instr_fetch dut (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .Start        (Start),
      .StartAddr    (StartAddr),
      .InstAddress  (InstAddress),
      .InstrIn      (InstrIn),
      .InstrValid   (InstrValid),
      .InstrReady   (InstrReady),
      .Instr        (Instr),
      .InstrPC      (InstrPC),
      .BranchTaken  (BranchTaken),
      .BranchTarget (BranchTarget),
      .Done         (Done),
      .CycleCount   (CycleCount)
   );

   assign InstrIn = rom[InstAddress];

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [IW-1:0] w;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   bit   ref_run = 0;
   bit   expect_done = 0;
   int   ref_cnt = 0;

   bit            have_prev = 0;
   logic [IW-1:0] prev_instr;
   logic [AW-1:0] prev_ipc;
   logic [AW-1:0] prev_addr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // A run delivers consecutive ROM words (wrapping) up to and including HALT.
   task automatic push_program(input logic [AW-1:0] a);
      logic [AW-1:0] p;
      p = a;
      exp_q.delete();
      for (int n = 0; n < 4096; n++) begin
         exp_q.push_back({p, rom[p]});
         if (rom[p] == HALT) break;
         p = p + AW'(1);
      end
   endtask

   task automatic set_prog(input logic [AW-1:0] a, input int len);
      logic [AW-1:0] p;
      p = a;
      for (int k = 0; k < len; k++) begin
         rom[p] = 9'($urandom_range(0, 9'h1FE));
         p = p + AW'(1);
      end
      rom[p] = HALT;
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic wait_idle(input int max_cyc, input string name);
      int n;
      n = 0;
      while (ref_run && n < max_cyc) begin
         tick();
         n++;
      end
      check({name, "_timeout"}, 32'(ref_run), 32'd0);
   endtask

   // Reference model: program start, redirects and cycle count, sampled at each edge
   always @(posedge Clk) begin
      if (Reset_n) begin
         if (Start && !ref_run) begin
            ref_run = 1;
            ref_cnt = 0;
            push_program(StartAddr);
         end else if (ref_run) begin
            ref_cnt++;
            if (BranchTaken && !expect_done) push_program(BranchTarget);
         end
      end
   end

   // Monitor: accepted transfers, stall hold, Done timing
   always @(negedge Clk) begin
      exp_t e;
      if (!Reset_n) begin
         have_prev = 0;
      end else begin
         if (expect_done) begin
            check("done_after_halt", 32'(Done), 32'd1);
            check("cyclecount_at_done", 32'(CycleCount), 32'(ref_cnt));
            check("valid_low_in_done", 32'(InstrValid), 32'd0);
            check("queue_empty_at_done", 32'(exp_q.size()), 32'd0);
            expect_done = 0;
            ref_run = 0;
         end else if (ref_run) begin
            check("done_low_while_running", 32'(Done), 32'd0);
         end
         if (have_prev) begin
            check("stall_valid_held", 32'(InstrValid), 32'd1);
            check("stall_instr_held", 32'(Instr), 32'(prev_instr));
            check("stall_pc_held", 32'(InstrPC), 32'(prev_ipc));
            check("stall_addr_held", 32'(InstAddress), 32'(prev_addr));
         end
         have_prev  = InstrValid && !InstrReady && !BranchTaken;
         prev_instr = Instr;
         prev_ipc   = InstrPC;
         prev_addr  = InstAddress;
         if (InstrValid && InstrReady && !BranchTaken) begin
            if (exp_q.size() == 0) begin
               check("unexpected_word_pc", 32'(InstrPC), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("accept_pc", 32'(InstrPC), 32'(e.pc));
               check("accept_instr", 32'(Instr), 32'(e.w));
               if (e.w == HALT) expect_done = 1;
            end
         end
      end
   end

   task automatic do_start(input logic [AW-1:0] a);
      StartAddr = a;
      Start = 1'b1;
      tick();
      Start = 1'b0;
   endtask

   initial begin
      Reset_n = 1'b0;
      Start = 1'b0;
      StartAddr = '0;
      InstrReady = 1'b1;
      BranchTaken = 1'b0;
      BranchTarget = '0;
      for (int i = 0; i < 4096; i++)
         rom[i] = (i % 16 == 15) ? HALT : 9'($urandom_range(0, 9'h1FE));
      #12;
      check("rst_valid", 32'(InstrValid), 32'd0);
      check("rst_instr", 32'(Instr), 32'd0);
      check("rst_ipc", 32'(InstrPC), 32'd0);
      check("rst_addr", 32'(InstAddress), 32'd0);
      check("rst_done", 32'(Done), 32'd0);
      check("rst_cnt", 32'(CycleCount), 32'd0);
      tick();
      Reset_n = 1'b1;
      tick();

      // basic three-word program
      rom[0] = 9'h010; rom[1] = 9'h011; rom[2] = HALT;
      do_start(12'h000);
      tick(); check("t1_instr1", 32'(Instr), 32'h010); check("t1_pc1", 32'(InstrPC), 32'h0);
      tick(); check("t1_instr2", 32'(Instr), 32'h011); check("t1_pc2", 32'(InstrPC), 32'h1);
      tick(); check("t1_instr3", 32'(Instr), 32'h1FF); check("t1_pc3", 32'(InstrPC), 32'h2);
      tick(); check("t1_done", 32'(Done), 32'd1); check("t1_cnt", 32'(CycleCount), 32'd4);
      wait_idle(10, "t1");

      // decode stall right after the first valid word
      do_start(12'h000);
      tick();
      InstrReady = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("t2_stall_instr", 32'(Instr), 32'h010);
         check("t2_stall_addr", 32'(InstAddress), 32'h1);
      end
      InstrReady = 1'b1;
      wait_idle(20, "t2");

      // redirect while the PC-5 word is on offer
      set_prog(12'h000, 10);
      set_prog(12'h100, 4);
      do_start(12'h000);
      begin
         int n;
         n = 0;
         while (!(InstrValid && InstrPC == 12'h005) && n < 20) begin
            tick();
            n++;
         end
         check("t3_reach_pc5", 32'(InstrPC), 32'h5);
      end
      BranchTaken = 1'b1;
      BranchTarget = 12'h100;
      tick();
      BranchTaken = 1'b0;
      check("t3_squash", 32'(InstrValid), 32'd0);
      tick();
      check("t3_target_instr", 32'(Instr), 32'(rom[256]));
      check("t3_target_pc", 32'(InstrPC), 32'h100);
      wait_idle(20, "t3");

      // address wrap from the top of the ROM
      rom[12'hFFE] = 9'h0A1; rom[12'hFFF] = 9'h0A2; rom[0] = 9'h0A3; rom[1] = HALT;
      do_start(12'hFFE);
      tick(); check("t4_pc_ffe", 32'(InstrPC), 32'hFFE);
      tick(); check("t4_pc_fff", 32'(InstrPC), 32'hFFF);
      tick(); check("t4_pc_000", 32'(InstrPC), 32'h000);
      tick(); check("t4_pc_001", 32'(InstrPC), 32'h001);
      tick(); check("t4_done", 32'(Done), 32'd1);
      wait_idle(10, "t4");

      // asynchronous reset in the middle of a run
      set_prog(12'h000, 8);
      do_start(12'h000);
      tick(); tick();
      check("t5_valid_before_rst", 32'(InstrValid), 32'd1);
      #3;
      Reset_n = 1'b0;
      #1;
      check("t5_rst_valid", 32'(InstrValid), 32'd0);
      check("t5_rst_instr", 32'(Instr), 32'd0);
      check("t5_rst_ipc", 32'(InstrPC), 32'd0);
      check("t5_rst_addr", 32'(InstAddress), 32'd0);
      check("t5_rst_cnt", 32'(CycleCount), 32'd0);
      ref_run = 0;
      expect_done = 0;
      exp_q.delete();
      tick(); tick();
      Reset_n = 1'b1;
      tick();
      set_prog(12'h020, 5);
      do_start(12'h020);
      wait_idle(20, "t5");

      // Start ignored mid-run
      set_prog(12'h040, 6);
      do_start(12'h040);
      tick(); tick();
      StartAddr = 12'h300;
      Start = 1'b1;
      tick();
      Start = 1'b0;
      wait_idle(20, "t6a");

      // redirect out of DRAIN back into RUN
      rom[12'h050] = HALT;
      set_prog(12'h060, 3);
      do_start(12'h050);
      InstrReady = 1'b0;
      tick();
      check("t6_halt_held", 32'(Instr), 32'(HALT));
      BranchTaken = 1'b1;
      BranchTarget = 12'h060;
      InstrReady = 1'b1;
      tick();
      BranchTaken = 1'b0;
      check("t6_no_done", 32'(Done), 32'd0);
      check("t6_squash", 32'(InstrValid), 32'd0);
      tick();
      check("t6_target_pc", 32'(InstrPC), 32'h060);
      wait_idle(20, "t6b");

      // randomized runs
      for (int i = 0; i < 4096; i++)
         rom[i] = (i % 16 == 15) ? HALT : 9'($urandom_range(0, 9'h1FE));
      for (int r = 0; r < 25; r++) begin
         InstrReady = 1'b1;
         do_start(12'($urandom));
         for (int c = 0; c < 300 && ref_run; c++) begin
            InstrReady   = ($urandom_range(0, 9) < 7);
            BranchTaken  = (c < 150) && ($urandom_range(0, 19) == 0);
            BranchTarget = 12'($urandom);
            Start        = ($urandom_range(0, 15) == 0);
            StartAddr    = 12'($urandom);
            tick();
         end
         Start = 1'b0;
         BranchTaken = 1'b0;
         InstrReady = 1'b1;
         wait_idle(60, "rand_run");
      end

      tick(); tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
